// File: rtl/pair_detect_sched_pkg.sv
// Shared types and the pair-detector transition function for pair_detect_sched.
package pair_detect_pkg;

    // Detector state encoding; IDLE and MATCH behave identically on the next bit,
    // which is what makes detection non-overlapping.
    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'b00;
    localparam state_t ONE   = 2'b01;
    localparam state_t ZERO  = 2'b10;
    localparam state_t MATCH = 2'b11;

    // Next detector state for one serial bit.
    function automatic state_t next_state(input state_t cur, input logic b);
        state_t nxt;
        case (cur)
            ONE:     nxt = b ? MATCH : ZERO;
            ZERO:    nxt = b ? ONE : MATCH;
            default: nxt = b ? ONE : ZERO;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pair_detect_sched_if.sv
// Channel-side bus of pair_detect_sched: requests, grants, results and counter read port.
interface pair_detect_sched_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) ();
    logic [NUM_CH-1:0]         req;
    logic [NUM_CH-1:0]         bit_in;
    logic [NUM_CH-1:0]         gnt;
    logic [NUM_CH-1:0]         clr;
    logic                      res_valid;
    logic [$clog2(NUM_CH)-1:0] res_ch;
    logic                      res_hit;
    logic [$clog2(NUM_CH)-1:0] rd_sel;
    logic [CNT_W-1:0]          rd_cnt;

    modport master (
        output req, bit_in, clr, rd_sel,
        input  gnt, res_valid, res_ch, res_hit, rd_cnt
    );

    modport slave (
        input  req, bit_in, clr, rd_sel,
        output gnt, res_valid, res_ch, res_hit, rd_cnt
    );
endinterface

// File: rtl/pair_detect_sched_rr_arbiter.sv
// Round-robin arbiter: first eligible request at or above ptr, wrapping around.
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] ptr,
    output logic [NUM_CH-1:0]         gnt,
    output logic [$clog2(NUM_CH)-1:0] idx,
    output logic                      any
);
    localparam int IW = $clog2(NUM_CH);

    int j;

    // Scan NUM_CH positions starting at ptr and take the first requester.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/pair_detect_sched.sv
// Time-shares one 00/11 pair detector across NUM_CH serial channels with
// per-channel context save/restore and saturating hit counters.
module pair_detect_sched
    import pair_detect_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic          clk,
    input  logic          reset,
    pair_detect_sched_if.slave bus
);
    localparam int IW = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] gnt_w;
    logic [IW-1:0]     gidx;
    logic              gany;
    logic [IW-1:0]     ptr;

    state_t            ctx [NUM_CH];
    logic [CNT_W-1:0]  cnt [NUM_CH];

    state_t            cur_st;
    state_t            nxt_st;
    logic              hit_p0;
    logic [CNT_W-1:0]  rd_p0;

    logic              vld_p1;
    logic [IW-1:0]     ch_p1;
    logic              hit_p1;
    logic [CNT_W-1:0]  rd_p1;

    // A channel being cleared is held off this cycle; reset blocks all grants.
    assign elig = reset ? '0 : (bus.req & ~bus.clr);

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req (elig),
        .ptr (ptr),
        .gnt (gnt_w),
        .idx (gidx),
        .any (gany)
    );

    assign bus.gnt = gnt_w;

    // ---- stage p0: restore granted context and run the detector ----
    assign cur_st = ctx[gidx];
    assign nxt_st = next_state(cur_st, bus.bit_in[gidx]);
    assign hit_p0 = (nxt_st == MATCH);
    assign rd_p0  = (int'(bus.rd_sel) < NUM_CH) ? cnt[bus.rd_sel] : '0;

    // Save the updated context, bump the counter, advance the pointer, apply clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ctx[i] <= IDLE;
                cnt[i] <= '0;
            end
        end else begin
            if (gany) begin
                ctx[gidx] <= nxt_st;
                if (hit_p0 && (cnt[gidx] != CNT_MAX)) begin
                    cnt[gidx] <= cnt[gidx] + 1'b1;
                end
                ptr <= (int'(gidx) == NUM_CH - 1) ? '0 : gidx + 1'b1;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.clr[i]) begin
                    ctx[i] <= IDLE;
                    cnt[i] <= '0;
                end
            end
        end
    end

    // ---- stage p1: one-cycle result strobe and counter readback ----
    // Register the result of this cycle's grant and the pre-update counter value.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            ch_p1  <= '0;
            hit_p1 <= 1'b0;
            rd_p1  <= '0;
        end else begin
            vld_p1 <= gany;
            ch_p1  <= gany ? gidx : '0;
            hit_p1 <= gany & hit_p0;
            rd_p1  <= rd_p0;
        end
    end

    assign bus.res_valid = vld_p1;
    assign bus.res_ch    = ch_p1;
    assign bus.res_hit   = hit_p1;
    assign bus.rd_cnt    = rd_p1;

endmodule

// File: tb/tb_pair_detect_sched.sv
// Directed bench for pair_detect_sched: one default instance and one with a 2-bit counter.
module tb_pair_detect_sched;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    pair_detect_sched_if #(.NUM_CH(4), .CNT_W(8)) if0 ();
    pair_detect_sched_if #(.NUM_CH(4), .CNT_W(2)) if1 ();

    pair_detect_sched #(.NUM_CH(4), .CNT_W(8)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    pair_detect_sched #(.NUM_CH(4), .CNT_W(2)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int e;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        if0.req = '0; if0.bit_in = '0; if0.clr = '0; if0.rd_sel = '0;
        if1.req = '0; if1.bit_in = '0; if1.clr = '0; if1.rd_sel = '0;

        // Reset state; grants are blocked while reset is high
        tick();
        if0.req = 4'b1111;
        #1 chk("gnt_in_reset", 32'(if0.gnt), 32'h0);
        tick();
        chk("rst_valid", 32'(if0.res_valid), 32'h0);
        chk("rst_ch", 32'(if0.res_ch), 32'h0);
        chk("rst_hit", 32'(if0.res_hit), 32'h0);
        chk("rst_rdcnt", 32'(if0.rd_cnt), 32'h0);
        if0.req = '0;
        reset = 1'b0;

        // Channel 0 alone sends 1,1,1,0,0 -> hits 0,1,0,0,1
        begin
            logic [4:0] bits;
            logic [4:0] hits;
            bits = 5'b00111;
            hits = 5'b10010;
            for (int i = 0; i < 5; i++) begin
                if0.req    = 4'b0001;
                if0.bit_in = {3'b000, bits[i]};
                #1 chk("s1_gnt", 32'(if0.gnt), 32'h1);
                tick();
                chk("s1_valid", 32'(if0.res_valid), 32'h1);
                chk("s1_ch", 32'(if0.res_ch), 32'h0);
                chk("s1_hit", 32'(if0.res_hit), 32'(hits[i]));
            end
        end
        if0.req = '0;
        tick();
        chk("s1_idle_valid", 32'(if0.res_valid), 32'h0);
        chk("s1_rdcnt", 32'(if0.rd_cnt), 32'h2);

        // All channels request; pointer sits at 1 after the last ch0 grant
        if0.req    = 4'b1111;
        if0.bit_in = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            e = (1 + c) % 4;
            #1 chk("s2_gnt", 32'(if0.gnt), 32'(1 << e));
            tick();
            chk("s2_valid", 32'(if0.res_valid), 32'h1);
            chk("s2_ch", 32'(if0.res_ch), 32'(e));
            chk("s2_hit", 32'(if0.res_hit), (c >= 4) ? 32'h1 : 32'h0);
        end

        // Interleaved ch1 (0,0) and ch2 (1,1); contexts stay separate
        if0.req    = 4'b0110;
        if0.bit_in = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("s3_ch", 32'(if0.res_ch), (c % 2 == 0) ? 32'h1 : 32'h2);
            chk("s3_hit", 32'(if0.res_hit), (c >= 2) ? 32'h1 : 32'h0);
        end

        // Put ch2 in ONE, move ptr to 2, then clear ch2 while it requests
        if0.req    = 4'b0100;
        if0.bit_in = 4'b0100;
        #1 chk("s4_gnt_a", 32'(if0.gnt), 32'h4);
        tick();
        if0.req    = 4'b0010;
        if0.bit_in = 4'b0010;
        tick();
        chk("s4_ch_b", 32'(if0.res_ch), 32'h1);
        if0.req    = 4'b1100;
        if0.bit_in = 4'b1100;
        if0.clr    = 4'b0100;
        if0.rd_sel = 2'd2;
        #1 chk("s4_gnt_clr", 32'(if0.gnt), 32'h8);
        tick();
        chk("s4_ch_c", 32'(if0.res_ch), 32'h3);
        chk("s4_rd_old", 32'(if0.rd_cnt), 32'h2);
        if0.clr = '0;
        #1 chk("s4_gnt_next", 32'(if0.gnt), 32'h4);
        tick();
        chk("s4_ch_d", 32'(if0.res_ch), 32'h2);
        chk("s4_hit_d", 32'(if0.res_hit), 32'h0);
        chk("s4_rd_clr", 32'(if0.rd_cnt), 32'h0);
        if0.req = 4'b0100;
        tick();
        chk("s4_hit_e", 32'(if0.res_hit), 32'h1);
        if0.req = '0;
        tick();
        chk("s4_rd_one", 32'(if0.rd_cnt), 32'h1);

        // 2-bit counter: ch0 streams zeros -> hit every 2nd bit, saturate at 3
        if1.req    = 4'b0001;
        if1.bit_in = 4'b0000;
        if1.rd_sel = 2'd0;
        for (int i = 0; i < 10; i++) begin
            #1 chk("s5_gnt", 32'(if1.gnt), 32'h1);
            tick();
            chk("s5_hit", 32'(if1.res_hit), (i % 2 == 1) ? 32'h1 : 32'h0);
            chk("s5_rd", 32'(if1.rd_cnt), ((i / 2) > 3) ? 32'h3 : 32'(i / 2));
        end
        if1.req = '0;
        tick();
        chk("s5_rd_sat", 32'(if1.rd_cnt), 32'h3);

        // Reset one cycle after a grant to ch1 (ctx ONE -> ZERO)
        if0.req    = 4'b0010;
        if0.bit_in = 4'b0000;
        tick();
        chk("s6_pre_valid", 32'(if0.res_valid), 32'h1);
        reset = 1'b1;
        #1 chk("s6_gnt_rst", 32'(if0.gnt), 32'h0);
        tick();
        chk("s6_valid", 32'(if0.res_valid), 32'h0);
        chk("s6_hit", 32'(if0.res_hit), 32'h0);
        chk("s6_rd", 32'(if0.rd_cnt), 32'h0);
        reset      = 1'b0;
        if0.req    = 4'b1111;
        if0.bit_in = 4'b0001;
        #1 chk("s6_ptr0", 32'(if0.gnt), 32'h1);
        tick();
        chk("s6_ch0_hit", 32'(if0.res_hit), 32'h0);
        if0.req    = 4'b0010;
        if0.bit_in = 4'b0000;
        #1 chk("s6_gnt1", 32'(if0.gnt), 32'h2);
        tick();
        chk("s6_ch1", 32'(if0.res_ch), 32'h1);
        chk("s6_ch1_idle", 32'(if0.res_hit), 32'h0);
        chk("s6_rd_after", 32'(if0.rd_cnt), 32'h0);
        if0.req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
